// File: rtl/complement_pkg.sv
// Shared definitions for the complement codec: conversion mode encoding.
package complement_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PASS  = 2'b00;
   localparam mode_t MODE_SM2TC = 2'b01;
   localparam mode_t MODE_TC2SM = 2'b10;
   localparam mode_t MODE_NEG   = 2'b11;

endpackage

// File: rtl/complement_lane.sv
// Combinational single-lane converter between sign-magnitude and two's
// complement, plus negate and pass-through. Flags results that cannot be
// represented in the target format.
module complement_lane
   import complement_pkg::*;
#(
   parameter int Width = 26
) (
   input  logic [Width-1:0] i_data,
   input  mode_t            i_mode,
   output logic [Width-1:0] o_data,
   output logic             o_ovf
);

   localparam logic [Width-1:0] MIN_VAL  = {1'b1, {(Width-1){1'b0}}};
   localparam logic [Width-1:0] ALL_ONES = {Width{1'b1}};
   localparam logic [Width-1:0] ONE      = {{(Width-1){1'b0}}, 1'b1};

   logic             w_sign;
   logic [Width-1:0] w_mag;
   logic [Width-1:0] w_neg_x;
   logic [Width-1:0] w_neg_mag;
   logic             w_is_min;

   assign w_sign    = i_data[Width-1];
   assign w_mag     = {1'b0, i_data[Width-2:0]};
   assign w_neg_x   = ~i_data + ONE;
   assign w_neg_mag = ~w_mag + ONE;
   assign w_is_min  = (i_data == MIN_VAL);

   // Select the conversion result and overflow flag for the requested mode.
   always_comb begin
      o_data = i_data;
      o_ovf  = 1'b0;
      case (i_mode)
         MODE_PASS: begin
            o_data = i_data;
            o_ovf  = 1'b0;
         end
         MODE_SM2TC: begin
            o_ovf = 1'b0;
            if (!w_sign) begin
               o_data = i_data;
            end else if (w_mag == {Width{1'b0}}) begin
               // negative zero folds onto the single TC zero
               o_data = {Width{1'b0}};
            end else begin
               o_data = w_neg_mag;
            end
         end
         MODE_TC2SM: begin
            if (!w_sign) begin
               o_data = i_data;
               o_ovf  = 1'b0;
            end else if (w_is_min) begin
               // -2^(W-1) has no SM encoding: saturate to the largest magnitude
               o_data = ALL_ONES;
               o_ovf  = 1'b1;
            end else begin
               o_data = {1'b1, w_neg_x[Width-2:0]};
               o_ovf  = 1'b0;
            end
         end
         MODE_NEG: begin
            // ~MIN+1 wraps back to MIN, which is exactly the required output
            o_data = w_neg_x;
            o_ovf  = w_is_min;
         end
         default: begin
            o_data = i_data;
            o_ovf  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/complement_codec_pipe.sv
// Multi-lane complement converter with a registered valid/ready output stage,
// a one-entry skid register and a saturating overflow-event counter.
module complement_codec_pipe
   import complement_pkg::*;
#(
   parameter int Width    = 26,
   parameter int Lanes    = 1,
   parameter int CntWidth = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [1:0]               InMode,
   input  logic [Lanes*Width-1:0]   DataIn,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [Lanes*Width-1:0]   DataOut,
   output logic [Lanes-1:0]         OutOvf,
   input  logic                     ClrCount,
   output logic [CntWidth-1:0]      OvfCount
);

   localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};
   localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

   logic [Lanes*Width-1:0] w_conv_data;
   logic [Lanes-1:0]       w_conv_ovf;

   for (genvar g = 0; g < Lanes; g++) begin : g_lane
      complement_lane #(.Width(Width)) u_lane (
         .i_data (DataIn[g*Width +: Width]),
         .i_mode (mode_t'(InMode)),
         .o_data (w_conv_data[g*Width +: Width]),
         .o_ovf  (w_conv_ovf[g])
      );
   end

   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [Lanes*Width-1:0] r_out_data;
   logic [Lanes-1:0]       r_out_ovf;
   logic                   r_skid_valid;
   logic [Lanes*Width-1:0] r_skid_data;
   logic [Lanes-1:0]       r_skid_ovf;
   logic [CntWidth-1:0]    r_cnt;

   logic                   w_acc;
   logic                   w_cons;
   logic                   w_nxt_out_valid;
   logic [Lanes*Width-1:0] w_nxt_out_data;
   logic [Lanes-1:0]       w_nxt_out_ovf;
   logic                   w_nxt_skid_valid;
   logic [Lanes*Width-1:0] w_nxt_skid_data;
   logic [Lanes-1:0]       w_nxt_skid_ovf;

   assign w_acc  = InValid & r_in_ready;
   assign w_cons = r_out_valid & OutReady;

   // Next-state of the output and skid registers; converted beats are
   // stored so the output stage only ever moves finished results.
   always_comb begin
      w_nxt_out_valid  = r_out_valid;
      w_nxt_out_data   = r_out_data;
      w_nxt_out_ovf    = r_out_ovf;
      w_nxt_skid_valid = r_skid_valid;
      w_nxt_skid_data  = r_skid_data;
      w_nxt_skid_ovf   = r_skid_ovf;
      if (!r_out_valid || w_cons) begin
         if (r_skid_valid) begin
            // oldest beat lives in the skid entry and must go out first
            w_nxt_out_valid = 1'b1;
            w_nxt_out_data  = r_skid_data;
            w_nxt_out_ovf   = r_skid_ovf;
            if (w_acc) begin
               w_nxt_skid_valid = 1'b1;
               w_nxt_skid_data  = w_conv_data;
               w_nxt_skid_ovf   = w_conv_ovf;
            end else begin
               w_nxt_skid_valid = 1'b0;
            end
         end else if (w_acc) begin
            w_nxt_out_valid = 1'b1;
            w_nxt_out_data  = w_conv_data;
            w_nxt_out_ovf   = w_conv_ovf;
         end else begin
            w_nxt_out_valid = 1'b0;
         end
      end else begin
         if (w_acc) begin
            w_nxt_skid_valid = 1'b1;
            w_nxt_skid_data  = w_conv_data;
            w_nxt_skid_ovf   = w_conv_ovf;
         end else begin
            w_nxt_skid_valid = r_skid_valid;
         end
      end
   end

   // Pipeline registers; ready is derived from the next skid state so it
   // never has a combinational path from OutReady.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= {(Lanes*Width){1'b0}};
         r_out_ovf    <= {Lanes{1'b0}};
         r_skid_valid <= 1'b0;
         r_skid_data  <= {(Lanes*Width){1'b0}};
         r_skid_ovf   <= {Lanes{1'b0}};
      end else begin
         r_in_ready   <= ~w_nxt_skid_valid;
         r_out_valid  <= w_nxt_out_valid;
         r_out_data   <= w_nxt_out_data;
         r_out_ovf    <= w_nxt_out_ovf;
         r_skid_valid <= w_nxt_skid_valid;
         r_skid_data  <= w_nxt_skid_data;
         r_skid_ovf   <= w_nxt_skid_ovf;
      end
   end

   // Saturating count of consumed beats carrying any overflow flag; clear wins.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_cnt <= {CntWidth{1'b0}};
      end else if (ClrCount) begin
         r_cnt <= {CntWidth{1'b0}};
      end else if (w_cons && (|r_out_ovf) && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign InReady  = r_in_ready;
   assign OutValid = r_out_valid;
   assign DataOut  = r_out_data;
   assign OutOvf   = r_out_ovf;
   assign OvfCount = r_cnt;

endmodule

// File: tb/tb_complement_codec_pipe.sv
// Directed bench for complement_codec_pipe with Width=8, Lanes=2, CntWidth=2.
module tb_complement_codec_pipe;

   localparam int W  = 8;
   localparam int L  = 2;
   localparam int CW = 2;

   logic            Clk = 1'b0;
   logic            Rst;
   logic            InValid;
   logic            InReady;
   logic [1:0]      InMode;
   logic [L*W-1:0]  DataIn;
   logic            OutValid;
   logic            OutReady;
   logic [L*W-1:0]  DataOut;
   logic [L-1:0]    OutOvf;
   logic            ClrCount;
   logic [CW-1:0]   OvfCount;

   int n_vec = 0;
   int n_err = 0;

   complement_codec_pipe #(.Width(W), .Lanes(L), .CntWidth(CW)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .InValid  (InValid),
      .InReady  (InReady),
      .InMode   (InMode),
      .DataIn   (DataIn),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .DataOut  (DataOut),
      .OutOvf   (OutOvf),
      .ClrCount (ClrCount),
      .OvfCount (OvfCount)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d);
      InValid = v;
      InMode  = m;
      DataIn  = d;
   endtask

   initial begin
      Rst = 1'b1; OutReady = 1'b0; ClrCount = 1'b0;
      drive(1'b0, 2'b00, 16'h0000);
      step(); step();
      check_vec("rst_outvalid", 32'(OutValid), 32'h0);
      check_vec("rst_inready",  32'(InReady),  32'h0);
      check_vec("rst_dataout",  32'(DataOut),  32'h0);
      check_vec("rst_outovf",   32'(OutOvf),   32'h0);
      check_vec("rst_count",    32'(OvfCount), 32'h0);
      Rst = 1'b0;
      step();
      check_vec("post_rst_ready", 32'(InReady), 32'h1);

      // Conversion vectors, streaming at full rate.
      OutReady = 1'b1;
      drive(1'b1, 2'b01, 16'h8580); step();
      check_vec("sm2tc_valid", 32'(OutValid), 32'h1);
      check_vec("sm2tc_data",  32'(DataOut),  32'hFB00);
      check_vec("sm2tc_ovf",   32'(OutOvf),   32'h0);
      drive(1'b1, 2'b10, 16'hFB80); step();
      check_vec("tc2sm_data",  32'(DataOut),  32'h85FF);
      check_vec("tc2sm_ovf",   32'(OutOvf),   32'h1);
      check_vec("tc2sm_cnt",   32'(OvfCount), 32'h0);
      drive(1'b1, 2'b11, 16'h0180); step();
      check_vec("neg_data",    32'(DataOut),  32'hFF80);
      check_vec("neg_ovf",     32'(OutOvf),   32'h1);
      check_vec("neg_cnt",     32'(OvfCount), 32'h1);
      drive(1'b1, 2'b00, 16'h807F); step();
      check_vec("pass_data",   32'(DataOut),  32'h807F);
      check_vec("pass_ovf",    32'(OutOvf),   32'h0);
      check_vec("pass_cnt",    32'(OvfCount), 32'h2);
      drive(1'b1, 2'b11, 16'h0005); step();
      check_vec("neg0_data",   32'(DataOut),  32'h00FB);
      check_vec("neg0_ovf",    32'(OutOvf),   32'h0);
      drive(1'b1, 2'b10, 16'h7F81); step();
      check_vec("tc2sm_mix",   32'(DataOut),  32'h7FFF);
      check_vec("tc2sm_movf",  32'(OutOvf),   32'h0);
      drive(1'b0, 2'b00, 16'h0000); step();
      check_vec("drain_valid", 32'(OutValid), 32'h0);
      check_vec("drain_cnt",   32'(OvfCount), 32'h2);

      // Counter clear, then saturation after five overflow handshakes.
      ClrCount = 1'b1; step(); ClrCount = 1'b0;
      check_vec("clr_cnt", 32'(OvfCount), 32'h0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'b11, 16'h0080); step();
      end
      drive(1'b0, 2'b00, 16'h0000); step();
      check_vec("sat_cnt", 32'(OvfCount), 32'h3);
      drive(1'b1, 2'b11, 16'h0080); step();
      drive(1'b0, 2'b00, 16'h0000); ClrCount = 1'b1; step(); ClrCount = 1'b0;
      check_vec("clr_wins", 32'(OvfCount), 32'h0);

      // Backpressure: A, B, C, D with three stalled cycles.
      OutReady = 1'b0;
      drive(1'b1, 2'b00, 16'h0102); step();
      check_vec("bp_a_out",    32'(DataOut),  32'h0102);
      check_vec("bp_a_ready",  32'(InReady),  32'h1);
      drive(1'b1, 2'b00, 16'h0304); step();
      check_vec("bp_b_hold",   32'(DataOut),  32'h0102);
      check_vec("bp_b_ready",  32'(InReady),  32'h0);
      drive(1'b1, 2'b00, 16'h0506); step();
      check_vec("bp_c_hold",   32'(DataOut),  32'h0102);
      check_vec("bp_c_valid",  32'(OutValid), 32'h1);
      check_vec("bp_c_ready",  32'(InReady),  32'h0);
      OutReady = 1'b1; step();
      check_vec("bp_out_b",    32'(DataOut),  32'h0304);
      check_vec("bp_ready_up", 32'(InReady),  32'h1);
      step();
      check_vec("bp_out_c",    32'(DataOut),  32'h0506);
      drive(1'b1, 2'b00, 16'h0708); step();
      check_vec("bp_out_d",    32'(DataOut),  32'h0708);
      drive(1'b0, 2'b00, 16'h0000); step();
      check_vec("bp_empty",    32'(OutValid), 32'h0);

      // Reset while the output register and skid entry are both full.
      OutReady = 1'b0;
      drive(1'b1, 2'b11, 16'h0080); step();
      drive(1'b1, 2'b11, 16'h8000); step();
      check_vec("mr_full_valid", 32'(OutValid), 32'h1);
      check_vec("mr_full_ready", 32'(InReady),  32'h0);
      drive(1'b0, 2'b00, 16'h0000);
      Rst = 1'b1; OutReady = 1'b1; step();
      check_vec("mr_valid",  32'(OutValid), 32'h0);
      check_vec("mr_ready",  32'(InReady),  32'h0);
      check_vec("mr_cnt",    32'(OvfCount), 32'h0);
      Rst = 1'b0; step();
      check_vec("mr_ready_up", 32'(InReady),  32'h1);
      check_vec("mr_no_stale", 32'(OutValid), 32'h0);
      drive(1'b1, 2'b00, 16'h0A0B); step();
      check_vec("mr_first",    32'(DataOut),  32'h0A0B);
      check_vec("mr_first_v",  32'(OutValid), 32'h1);
      drive(1'b0, 2'b00, 16'h0000); step();
      check_vec("mr_alone",    32'(OutValid), 32'h0);
      check_vec("mr_cnt_end",  32'(OvfCount), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
